md_sched: RTL

- Sequencing controller for the shared multi-cycle multiply/divide resources used by the execute stage.
- Accepts one HI/LO arithmetic op (mult/multu/div/divu) from EX and drives the pipelined multiplier or the iterative divider.
- Raises the EX stall request until the result is ready, then issues a single HI/LO write pulse timed to the instruction leaving EX.
- Handles flush (annul) and divide-by-zero without involving the divider.

---
 rtl/md_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// Sequencer for the shared HI/LO multiply/divide units: stalls EX, waits for the result, writes HI/LO once.
// Optional divider watchdog enabled by defining MD_DIV_TIMEOUT_EN.
module md_sched #(
  parameter int MUL_LAT = 2,
  parameter int DIV_MAX = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        ex_advance,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_annul,
  input  logic [63:0] div_result,
  input  logic        div_ready,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy,
`ifdef MD_DIV_TIMEOUT_EN
  output logic        div_timeout,
`endif
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL_WAIT, S_DIV_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          sgn_q, sgn_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef MD_DIV_TIMEOUT_EN
  localparam int WW = $clog2(DIV_MAX + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          to_q, to_d;
`endif

  logic legal, is_mul, sgn_req;
  logic div_start_c, div_annul_c, hilo_we_c;

  // req_op bit order: [3]=mult, [2]=multu, [1]=div, [0]=divu
  assign legal   = req_valid && (req_op != 4'd0) && ((req_op & (req_op - 4'd1)) == 4'd0);
  assign is_mul  = req_op[3] | req_op[2];
  assign sgn_req = req_op[3] | req_op[1];

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    sgn_d       = sgn_q;
    cnt_d       = cnt_q;
    div_start_c = 1'b0;
    div_annul_c = 1'b0;
    hilo_we_c   = 1'b0;
`ifdef MD_DIV_TIMEOUT_EN
    wd_d        = wd_q;
    to_d        = to_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (legal && !flush) begin
          op_a_d = src_a;
          op_b_d = src_b;
          sgn_d  = sgn_req;
          if (is_mul) begin
            state_d = S_MUL_WAIT;
            cnt_d   = CW'(1);
          end else if (src_b == 32'd0) begin
            // Divide by zero never reaches the divider.
            state_d = S_DONE;
            hi_d    = src_a;
            lo_d    = 32'hFFFF_FFFF;
          end else begin
            state_d = S_DIV_RUN;
`ifdef MD_DIV_TIMEOUT_EN
            wd_d    = '0;
`endif
          end
        end
      end
      S_MUL_WAIT: begin
        if (cnt_q == CW'(MUL_LAT)) begin
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV_RUN: begin
        if (div_ready) begin
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
          state_d = S_DONE;
        end else begin
          div_start_c = 1'b1;
`ifdef MD_DIV_TIMEOUT_EN
          if (wd_q == WW'(DIV_MAX - 1)) begin
            div_start_c = 1'b0;
            div_annul_c = 1'b1;
            hi_d        = 32'd0;
            lo_d        = 32'd0;
            to_d        = 1'b1;
            state_d     = S_DONE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        // Hold the result until the instruction actually leaves EX.
        if (ex_advance) begin
          hilo_we_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      hilo_we_c   = 1'b0;
      div_start_c = 1'b0;
      div_annul_c = (state_q == S_DIV_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef MD_DIV_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
`ifdef MD_DIV_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign mul_signed = (state_q == S_MUL_WAIT) && sgn_q;
  assign mul_ina    = (state_q == S_MUL_WAIT) ? op_a_q : 32'd0;
  assign mul_inb    = (state_q == S_MUL_WAIT) ? op_b_q : 32'd0;
  assign div_signed = (state_q == S_DIV_RUN) && sgn_q;
  assign div_opa    = (state_q == S_DIV_RUN) ? op_a_q : 32'd0;
  assign div_opb    = (state_q == S_DIV_RUN) ? op_b_q : 32'd0;
  assign div_start  = div_start_c;
  assign div_annul  = div_annul_c;
  assign hilo_we    = hilo_we_c;
  assign hi_wdata   = hi_q;
  assign lo_wdata   = lo_q;
  assign stall_req  = ((state_q == S_IDLE) && legal) || (state_q == S_MUL_WAIT) ||
                      (state_q == S_DIV_RUN);
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;
`ifdef MD_DIV_TIMEOUT_EN
  assign div_timeout = to_q;
`endif

endmodule
